// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequencer and its frame-synchronous helpers.
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_HOLD   = 2'b10
    } mode_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    localparam int DEF_NUM_PATTERNS = 4;
    localparam int DEF_RGB_W        = 6;

endpackage

// File: rtl/frame_tick_gen.sv
// Registers vsync and flags the first cycle it is seen high after being low.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic tick
);

    logic vsync_q;

    // Reset high so a vsync already high at release does not fake a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign tick = vsync & ~vsync_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Sequences NUM_PATTERNS generators onto the VGA output with auto, manual and hold
// modes, optional blank frames on each switch, and per-pattern advance/reset strobes.
module pattern_sequencer
    import pattern_pkg::*;
#(
    parameter int NUM_PATTERNS = DEF_NUM_PATTERNS,
    parameter int RGB_W        = DEF_RGB_W,
    parameter int DWELL_W      = 9,
    parameter int BLANK_FRAMES = 1,
    parameter int IDX_W        = $clog2(NUM_PATTERNS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          paused,
    input  logic [1:0]                    mode,
    input  logic                          step_req,
    input  logic [IDX_W-1:0]              sel_idx,
    input  logic [DWELL_W-1:0]            dwell_frames,
    input  logic [NUM_PATTERNS*RGB_W-1:0] pat_rgb,
    output logic [RGB_W-1:0]              rgb,
    output logic [IDX_W-1:0]              active_idx,
    output logic [NUM_PATTERNS-1:0]       next_frame,
    output logic [NUM_PATTERNS-1:0]       pattern_rst,
    output logic                          switch_pulse,
    output logic                          blanking
);

    localparam logic [1:0] BLANK_LAST = (BLANK_FRAMES > 0) ? 2'(BLANK_FRAMES - 1) : 2'd0;

    logic                    tick;
    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx_nxt, idx_inc, target;
    logic [DWELL_W-1:0]      dwell_cnt, dwell_nxt, dwell_eff;
    logic [1:0]              blank_cnt, blank_nxt;
    logic                    step_pending, step_nxt, step_any;
    logic                    switch_now;
    logic [NUM_PATTERNS-1:0] pattern_rst_nxt;

    frame_tick_gen u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .vsync (vsync),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            active_idx   <= '0;
            dwell_cnt    <= '0;
            blank_cnt    <= '0;
            step_pending <= 1'b0;
            switch_pulse <= 1'b0;
            pattern_rst  <= '0;
        end else begin
            state        <= state_nxt;
            active_idx   <= idx_nxt;
            dwell_cnt    <= dwell_nxt;
            blank_cnt    <= blank_nxt;
            step_pending <= step_nxt;
            switch_pulse <= switch_now;
            pattern_rst  <= pattern_rst_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = active_idx;
        dwell_nxt       = dwell_cnt;
        blank_nxt       = blank_cnt;
        step_any        = step_pending | step_req;
        step_nxt        = step_any;
        switch_now      = 1'b0;
        target          = active_idx;
        pattern_rst_nxt = '0;
        idx_inc         = (active_idx == IDX_W'(NUM_PATTERNS - 1)) ? '0 : active_idx + 1'b1;
        dwell_eff       = (dwell_frames == '0) ? DWELL_W'(1) : dwell_frames;

        if (tick) begin
            if (state == ST_RUN) begin
                // A step request arriving with the tick is consumed by it.
                step_nxt = 1'b0;
                case (mode)
                    MODE_AUTO: begin
                        if ((dwell_cnt >= dwell_eff - 1'b1) || step_any) begin
                            switch_now = 1'b1;
                            target     = idx_inc;
                        end
                    end
                    MODE_MANUAL: begin
                        if ((sel_idx != active_idx) && (int'(sel_idx) < NUM_PATTERNS)) begin
                            switch_now = 1'b1;
                            target     = sel_idx;
                        end
                    end
                    default: begin
                        if (step_any) begin
                            switch_now = 1'b1;
                            target     = idx_inc;
                        end
                    end
                endcase

                if (switch_now) begin
                    idx_nxt   = target;
                    dwell_nxt = '0;
                    if (BLANK_FRAMES > 0) begin
                        state_nxt = ST_BLANK;
                        blank_nxt = '0;
                    end
                end else if ((mode == MODE_AUTO) && !paused && (dwell_cnt != '1)) begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end else begin
                if (blank_cnt == BLANK_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    blank_nxt = blank_cnt + 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
            pattern_rst_nxt[i] = switch_now && (target == IDX_W'(i));
        end
    end

    always_comb begin
        blanking   = (state == ST_BLANK);
        rgb        = '0;
        next_frame = '0;
        for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
            if (active_idx == IDX_W'(i)) begin
                if (!blanking) begin
                    rgb = pat_rgb[i*RGB_W +: RGB_W];
                end
                next_frame[i] = tick & ~paused & (state == ST_RUN);
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench: three sequencer instances (4 patterns/no blank, 4 patterns/2 blank, 5 patterns).
module tb_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        paused;
    logic [1:0]  mode;
    logic        step_req;
    logic [2:0]  sel;
    logic [8:0]  dwell;
    logic [29:0] pat;

    logic [5:0] rgb_b0, rgb_b2, rgb_n5;
    logic [1:0] idx_b0, idx_b2;
    logic [2:0] idx_n5;
    logic [3:0] nf_b0, pr_b0, nf_b2, pr_b2;
    logic [4:0] nf_n5, pr_n5;
    logic       sp_b0, bl_b0, sp_b2, bl_b2, sp_n5, bl_n5;

    // Values captured inside the tick cycle (d_) and one cycle after it (a_).
    logic [3:0] d_nf0, d_nf2, a_pr0, a_pr2;
    logic [1:0] d_idx0, d_idx2, a_idx0, a_idx2;
    logic [2:0] a_idx5;
    logic [5:0] d_rgb2, a_rgb0, a_rgb2;
    logic       d_bl2, a_sp0, a_sp2, a_bl2, a_sp5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_sequencer #(.NUM_PATTERNS(4), .RGB_W(6), .DWELL_W(9), .BLANK_FRAMES(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused), .mode(mode),
        .step_req(step_req), .sel_idx(sel[1:0]), .dwell_frames(dwell), .pat_rgb(pat[23:0]),
        .rgb(rgb_b0), .active_idx(idx_b0), .next_frame(nf_b0), .pattern_rst(pr_b0),
        .switch_pulse(sp_b0), .blanking(bl_b0)
    );

    pattern_sequencer #(.NUM_PATTERNS(4), .RGB_W(6), .DWELL_W(9), .BLANK_FRAMES(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused), .mode(mode),
        .step_req(step_req), .sel_idx(sel[1:0]), .dwell_frames(dwell), .pat_rgb(pat[23:0]),
        .rgb(rgb_b2), .active_idx(idx_b2), .next_frame(nf_b2), .pattern_rst(pr_b2),
        .switch_pulse(sp_b2), .blanking(bl_b2)
    );

    pattern_sequencer #(.NUM_PATTERNS(5), .RGB_W(6), .DWELL_W(9), .BLANK_FRAMES(0)) u_n5 (
        .clk(clk), .rst_n(rst_n), .vsync(vsync), .paused(paused), .mode(mode),
        .step_req(step_req), .sel_idx(sel), .dwell_frames(dwell), .pat_rgb(pat),
        .rgb(rgb_n5), .active_idx(idx_n5), .next_frame(nf_n5), .pattern_rst(pr_n5),
        .switch_pulse(sp_n5), .blanking(bl_n5)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        vsync    = 1'b1;
        step_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One video frame: vsync low for a few cycles, then the rising edge gives the tick.
    task automatic frame(input bit step_in_tick);
        @(posedge clk);
        #1 vsync = 1'b0;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1;
        if (step_in_tick) step_req = 1'b1;
        @(negedge clk);
        d_nf0 = nf_b0; d_idx0 = idx_b0;
        d_nf2 = nf_b2; d_idx2 = idx_b2; d_bl2 = bl_b2; d_rgb2 = rgb_b2;
        @(posedge clk);
        #1 step_req = 1'b0;
        a_sp0 = sp_b0; a_pr0 = pr_b0; a_idx0 = idx_b0; a_rgb0 = rgb_b0;
        a_sp2 = sp_b2; a_pr2 = pr_b2; a_idx2 = idx_b2; a_bl2 = bl_b2; a_rgb2 = rgb_b2;
        a_sp5 = sp_n5; a_idx5 = idx_n5;
    endtask

    task automatic step_pulse();
        @(posedge clk);
        #1 step_req = 1'b1;
        @(posedge clk);
        #1 step_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned exp_idx[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int unsigned exp_nf[13]  = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 8, 8, 8, 1};
        int unsigned exp_pr[13]  = '{0, 0, 2, 0, 0, 4, 0, 0, 8, 0, 0, 1, 0};
        int unsigned exp_rgb[13] = '{10, 10, 20, 20, 20, 30, 30, 30, 40, 40, 40, 10, 10};

        pat    = {6'd50, 6'd40, 6'd30, 6'd20, 6'd10};
        paused = 1'b0;
        mode   = 2'b00;
        sel    = 3'd0;
        dwell  = 9'd3;
        do_reset();
        #1;
        check_val("rst_idx", idx_b0, 0);
        check_val("rst_rgb", rgb_b0, 10);
        check_val("rst_sp", sp_b0, 0);
        check_val("rst_pr", pr_b0, 0);
        check_val("rst_nf", nf_b0, 0);
        check_val("rst_blank", bl_b2, 0);

        // AUTO, dwell 3, no blanking
        for (int k = 0; k < 13; k++) begin
            frame(1'b0);
            check_val("auto_idx", d_idx0, exp_idx[k]);
            check_val("auto_nf", d_nf0, exp_nf[k]);
            check_val("auto_pr", a_pr0, exp_pr[k]);
            check_val("auto_sp", a_sp0, (exp_pr[k] != 0) ? 1 : 0);
            check_val("auto_rgb", a_rgb0, exp_rgb[k]);
        end

        // Pause freezes dwell counting and animation strobes
        do_reset();
        frame(1'b0);
        check_val("pause_pre_sp", a_sp0, 0);
        paused = 1'b1;
        for (int k = 0; k < 10; k++) begin
            frame(1'b0);
            check_val("pause_nf", d_nf0, 0);
            check_val("pause_idx", a_idx0, 0);
            check_val("pause_sp", a_sp0, 0);
        end
        check_val("pause_dwell", u_b0.dwell_cnt, 1);
        paused = 1'b0;
        frame(1'b0);
        check_val("unpause_nf", d_nf0, 1);
        check_val("unpause_sp", a_sp0, 0);
        frame(1'b0);
        check_val("unpause_sw", a_sp0, 1);
        check_val("unpause_idx", a_idx0, 1);

        // Step request on the same tick as dwell expiry: one advance
        do_reset();
        frame(1'b0);
        frame(1'b0);
        frame(1'b1);
        check_val("coinc_sp", a_sp0, 1);
        check_val("coinc_idx", a_idx0, 1);
        check_val("coinc_pr", a_pr0, 4'b0010);
        check_val("coinc_pend", u_b0.step_pending, 0);
        frame(1'b0);
        check_val("coinc_next_sp", a_sp0, 0);
        check_val("coinc_next_idx", a_idx0, 1);

        // MANUAL: in-range change, out-of-range, unchanged; then HOLD and reserved mode
        do_reset();
        mode = 2'b01;
        sel  = 3'd2;
        frame(1'b0);
        check_val("man_sp5", a_sp5, 1);
        check_val("man_idx5", a_idx5, 2);
        check_val("man_sp0", a_sp0, 1);
        check_val("man_pr0", a_pr0, 4'b0100);
        sel = 3'd5;
        frame(1'b0);
        check_val("man_oor_sp", a_sp5, 0);
        check_val("man_oor_idx", a_idx5, 2);
        sel = 3'd2;
        frame(1'b0);
        check_val("man_same_sp", a_sp5, 0);
        step_pulse();
        check_val("man_pend_set", u_n5.step_pending, 1);
        frame(1'b0);
        check_val("man_step_sp", a_sp5, 0);
        check_val("man_pend_clr", u_n5.step_pending, 0);
        mode = 2'b10;
        frame(1'b0);
        check_val("hold_sp", a_sp5, 0);
        mode = 2'b11;
        step_pulse();
        frame(1'b0);
        check_val("rsv_step_sp", a_sp5, 1);
        check_val("rsv_step_idx", a_idx5, 3);

        // AUTO long dwell, mid-frame step, two blank frames
        do_reset();
        mode  = 2'b00;
        dwell = 9'd300;
        frame(1'b0);
        check_val("blk_nosw", a_sp2, 0);
        step_pulse();
        frame(1'b0);
        check_val("blk_sp", a_sp2, 1);
        check_val("blk_idx", a_idx2, 1);
        check_val("blk_pr", a_pr2, 4'b0010);
        check_val("blk_on", a_bl2, 1);
        check_val("blk_rgb", a_rgb2, 0);
        frame(1'b0);
        check_val("blk1_bl", d_bl2, 1);
        check_val("blk1_nf", d_nf2, 0);
        check_val("blk1_rgb", d_rgb2, 0);
        check_val("blk1_after", a_bl2, 1);
        frame(1'b0);
        check_val("blk2_bl", d_bl2, 1);
        check_val("blk2_nf", d_nf2, 0);
        check_val("blk2_after", a_bl2, 0);
        check_val("blk2_rgb", a_rgb2, 20);
        frame(1'b0);
        check_val("run_nf", d_nf2, 4'b0010);
        check_val("run_idx", d_idx2, 1);
        check_val("run_sp", a_sp2, 0);

        // Reset asserted mid-BLANK takes effect without a clock edge
        do_reset();
        step_pulse();
        frame(1'b0);
        check_val("rb_enter", a_bl2, 1);
        @(posedge clk);
        #1 vsync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rb_bl", bl_b2, 0);
        check_val("rb_idx", idx_b2, 0);
        check_val("rb_rgb", rgb_b2, 10);
        check_val("rb_sp", sp_b2, 0);
        check_val("rb_pr", pr_b2, 0);
        check_val("rb_nf", nf_b2, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame(1'b0);
        check_val("rb_first_sp", a_sp2, 0);
        check_val("rb_first_idx", a_idx2, 0);
        check_val("rb_first_nf", d_nf2, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
